// File: rtl/comb_lock_pkg.sv
// Shared types and default constants for the four-digit combination lock.
package comb_lock_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DIG1,
    DIG2,
    DIG3,
    DIG4,
    GRANT,
    DENY,
    LOCKED
  } state_t;

  localparam logic [3:0] DEF_CODE0       = 4'd1;
  localparam logic [3:0] DEF_CODE1       = 4'd5;
  localparam logic [3:0] DEF_CODE2       = 4'd3;
  localparam logic [3:0] DEF_CODE3       = 4'd7;
  localparam int         DEF_MAX_FAILS   = 3;
  localparam int         DEF_LOCK_CYCLES = 20;

endpackage

// File: rtl/comb_lock.sv
// Combination lock: enter, four sampled digits, one-cycle grant/deny pulse,
// timed lockout after MAX_FAILS consecutive wrong attempts.
module comb_lock
  import comb_lock_pkg::*;
#(
  parameter logic [3:0] CODE0       = DEF_CODE0,
  parameter logic [3:0] CODE1       = DEF_CODE1,
  parameter logic [3:0] CODE2       = DEF_CODE2,
  parameter logic [3:0] CODE3       = DEF_CODE3,
  parameter int         MAX_FAILS   = DEF_MAX_FAILS,
  parameter int         LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enter_button,
  input  logic [3:0] ip_pass,
  output logic       grant,
  output logic       deny,
  output logic       lock
);

  localparam int FAIL_W  = $clog2(MAX_FAILS + 1);
  localparam int TIMER_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(LOCK_CYCLES - 1);

  state_t              state;
  logic                mismatch;
  logic [FAIL_W-1:0]   fail_count;
  logic [TIMER_W-1:0]  timer;
  logic                digit_miss;
  logic                last_fail;

  always_comb begin
    digit_miss = 1'b0;
    case (state)
      DIG1:    digit_miss = (ip_pass != CODE0);
      DIG2:    digit_miss = (ip_pass != CODE1);
      DIG3:    digit_miss = (ip_pass != CODE2);
      DIG4:    digit_miss = (ip_pass != CODE3);
      default: digit_miss = 1'b0;
    endcase
  end

  assign last_fail = (int'(fail_count) + 1 >= MAX_FAILS);

  // Outputs are registered alongside the state so they equal a decode of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mismatch   <= 1'b0;
      fail_count <= '0;
      timer      <= '0;
      grant      <= 1'b0;
      deny       <= 1'b0;
      lock       <= 1'b0;
    end else begin
      grant <= 1'b0;
      deny  <= 1'b0;
      lock  <= 1'b0;
      case (state)
        IDLE: begin
          if (enter_button) begin
            state    <= DIG1;
            mismatch <= 1'b0;
          end
        end
        DIG1: begin
          state    <= DIG2;
          mismatch <= mismatch | digit_miss;
        end
        DIG2: begin
          state    <= DIG3;
          mismatch <= mismatch | digit_miss;
        end
        DIG3: begin
          state    <= DIG4;
          mismatch <= mismatch | digit_miss;
        end
        DIG4: begin
          mismatch <= mismatch | digit_miss;
          if (!(mismatch | digit_miss)) begin
            state      <= GRANT;
            grant      <= 1'b1;
            fail_count <= '0;
          end else if (!last_fail) begin
            state      <= DENY;
            deny       <= 1'b1;
            fail_count <= fail_count + 1'b1;
          end else begin
            state <= LOCKED;
            lock  <= 1'b1;
            timer <= TIMER_LOAD;
          end
        end
        GRANT, DENY: begin
          state <= IDLE;
        end
        LOCKED: begin
          if (timer == '0) begin
            state      <= IDLE;
            fail_count <= '0;
          end else begin
            timer <= timer - 1'b1;
            lock  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comb_lock.sv
// Directed bench for comb_lock with default code 1,5,3,7, 3 fails, 20-cycle lockout.
module tb_comb_lock;

  logic       clk;
  logic       rst;
  logic       enter_button;
  logic [3:0] ip_pass;
  logic       grant;
  logic       deny;
  logic       lock;

  int checks = 0;
  int errors = 0;

  comb_lock dut (
    .clk          (clk),
    .rst          (rst),
    .enter_button (enter_button),
    .ip_pass      (ip_pass),
    .grant        (grant),
    .deny         (deny),
    .lock         (lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed {grant,deny,lock}=%b expected %b", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are checked there too.
  // Expected result is {grant,deny,lock} one half-cycle after E4.
  task automatic attempt(input string tag, input logic [3:0] d0, input logic [3:0] d1,
                         input logic [3:0] d2, input logic [3:0] d3,
                         input logic [2:0] exp_res);
    logic [3:0] ds [4];
    ds[0] = d0; ds[1] = d1; ds[2] = d2; ds[3] = d3;
    @(negedge clk);
    enter_button = 1'b1;
    ip_pass      = 4'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      enter_button = (i == 1);  // stray press mid-entry must not restart the attempt
      ip_pass      = ds[i];
      chk({tag, "_entry"}, {grant, deny, lock}, 3'b000);
    end
    @(negedge clk);
    enter_button = 1'b0;
    ip_pass      = 4'd0;
    chk({tag, "_result"}, {grant, deny, lock}, exp_res);
    @(negedge clk);
    chk({tag, "_after"}, {grant, deny, lock}, {2'b00, exp_res[0]});
  endtask

  initial begin
    rst          = 1'b1;
    enter_button = 1'b1;
    ip_pass      = 4'd0;
    repeat (2) @(negedge clk);
    chk("reset_state", {grant, deny, lock}, 3'b000);
    rst          = 1'b0;
    enter_button = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {grant, deny, lock}, 3'b000);

    attempt("correct", 4'd1, 4'd5, 4'd3, 4'd7, 3'b100);
    attempt("wrong_first", 4'd2, 4'd0, 4'd0, 4'd0, 3'b010);
    attempt("wrong_last", 4'd1, 4'd5, 4'd3, 4'd6, 3'b010);
    attempt("correct_clear", 4'd1, 4'd5, 4'd3, 4'd7, 3'b100);

    // Lockout: deny, deny, lock; we are then one cycle into the 20-cycle lock.
    attempt("lk_w1", 4'd2, 4'd0, 4'd0, 4'd0, 3'b010);
    attempt("lk_w2", 4'd1, 4'd1, 4'd1, 4'd1, 3'b010);
    attempt("lk_w3", 4'd0, 4'd0, 4'd0, 4'd0, 3'b001);
    for (int k = 2; k < 20; k++) begin
      @(negedge clk);
      enter_button = (k == 2);
      case (k)
        3:       ip_pass = 4'd1;
        4:       ip_pass = 4'd5;
        5:       ip_pass = 4'd3;
        6:       ip_pass = 4'd7;
        default: ip_pass = 4'd0;
      endcase
      chk($sformatf("lock_hold_%0d", k), {grant, deny, lock}, 3'b001);
    end
    @(negedge clk);
    enter_button = 1'b0;
    ip_pass      = 4'd0;
    chk("lock_released", {grant, deny, lock}, 3'b000);

    attempt("unlock_correct", 4'd1, 4'd5, 4'd3, 4'd7, 3'b100);
    attempt("unlock_wrong", 4'd9, 4'd9, 4'd9, 4'd9, 3'b010);
    attempt("unlock_correct2", 4'd1, 4'd5, 4'd3, 4'd7, 3'b100);

    // Counter cleared by grant: wrong, wrong, correct, wrong, wrong.
    attempt("cc_w1", 4'd1, 4'd5, 4'd0, 4'd7, 3'b010);
    attempt("cc_w2", 4'd0, 4'd5, 4'd3, 4'd7, 3'b010);
    attempt("cc_ok", 4'd1, 4'd5, 4'd3, 4'd7, 3'b100);
    attempt("cc_w3", 4'd1, 4'd4, 4'd3, 4'd7, 3'b010);
    attempt("cc_w4", 4'd15, 4'd15, 4'd15, 4'd15, 3'b010);

    // Fail count is 2 here; reset during DIG3 must clear it.
    @(negedge clk);
    enter_button = 1'b1;
    @(negedge clk);
    enter_button = 1'b0;
    ip_pass      = 4'd1;
    @(negedge clk);
    ip_pass = 4'd5;
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_dig3", {grant, deny, lock}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    attempt("post_rst_wrong", 4'd2, 4'd2, 4'd2, 4'd2, 3'b010);
    attempt("post_rst_ok", 4'd1, 4'd5, 4'd3, 4'd7, 3'b100);

    // Reset in the middle of a lockout drops lock at once and clears the count.
    attempt("rl_w1", 4'd2, 4'd0, 4'd0, 4'd0, 3'b010);
    attempt("rl_w2", 4'd2, 4'd0, 4'd0, 4'd0, 3'b010);
    attempt("rl_w3", 4'd2, 4'd0, 4'd0, 4'd0, 3'b001);
    repeat (5) @(negedge clk);
    chk("rl_locked", {grant, deny, lock}, 3'b001);
    #2 rst = 1'b1;
    #1 chk("rst_locked", {grant, deny, lock}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_locked_held", {grant, deny, lock}, 3'b000);
    attempt("rl_after_w1", 4'd3, 4'd3, 4'd3, 4'd3, 3'b010);
    attempt("rl_after_w2", 4'd3, 4'd3, 4'd3, 4'd3, 3'b010);
    attempt("rl_after_ok", 4'd1, 4'd5, 4'd3, 4'd7, 3'b100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
